// File: rtl/cache_writeback_buffer.sv
// Victim/writeback buffer: a circular FIFO of dirty lines that drain to physical memory
// one at a time, and that cache misses can snoop so they never re-fetch stale data.
module cache_writeback_buffer #(
  parameter int DEPTH    = 4,
  parameter int s_offset = 5,
  parameter int s_line   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   evict_valid,
  input  logic [31:0]            evict_addr,
  input  logic [s_line-1:0]      evict_data,
  output logic                   evict_ready,
  input  logic [31:0]            lookup_addr,
  output logic                   lookup_hit,
  output logic [s_line-1:0]      lookup_data,
  output logic [31:0]            pmem_address,
  output logic [s_line-1:0]      pmem_wdata,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 32 - s_offset;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [TW-1:0]     tag_q  [DEPTH];
  logic [s_line-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     lookup_idx;
  logic              push;
  logic              pop;
  logic              unused_offset_bits;

  // Line offsets never take part in matching or storage.
  assign unused_offset_bits = ^{evict_addr[s_offset-1:0], lookup_addr[s_offset-1:0]};

  // Ready looks only at the registered count, so a pop while full frees a slot a cycle later.
  assign evict_ready = (count != CW'(DEPTH));
  assign empty       = (count == '0);
  assign push        = evict_valid && evict_ready;
  assign pop         = (state == WRITE) && pmem_resp;

  assign pmem_address = {tag_q[head], {s_offset{1'b0}}};
  assign pmem_wdata   = data_q[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      state      <= IDLE;
      pmem_write <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let push and pop both read this cycle's pointers and count.
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= WRITE;
            pmem_write <= 1'b1;
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: line storage is deliberately not reset; valid_q alone says whether an entry is live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail]  <= evict_addr[31:s_offset];
      data_q[tail] <= evict_data;
    end
  end

  // Scan oldest to youngest so a later match overrides, leaving the youngest entry's data.
  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx = head + PW'(i);
      if (valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_addr[31:s_offset])) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lookup_idx];
      end
    end
  end

endmodule
